// File: rtl/ms_pkg.sv
// ms_pkg: shared definitions for the minesweeper generator.
//   - Board geometry (BOARD_W, CELLS, ADJ_W) and the cell index type.
//   - Generator FSM state encoding and a packed debug view of the FSM.
//   - nbr_mask(): in-board 8-neighbour mask of a cell. It is used both by the
//     adjacency sweep and by the safe-cell exclusion.
//   - count_adj(): number of mined neighbours of a cell.
// Optional feature macro: MS_GEN_SAFE_CELL_EN. It lowers MAX_MINES because up
// to 9 cells can be kept mine-free.
package ms_pkg;

  localparam int BOARD_W = 8;
  localparam int CELLS   = BOARD_W * BOARD_W;
  localparam int ADJ_W   = 4;

  typedef logic [5:0] cell_idx_t;
  typedef logic [2:0] gen_state_t;

  localparam gen_state_t GS_IDLE  = 3'd0;
  localparam gen_state_t GS_CLEAR = 3'd1;
  localparam gen_state_t GS_PICK  = 3'd2;
  localparam gen_state_t GS_COUNT = 3'd3;
  localparam gen_state_t GS_DONE  = 3'd4;

`ifdef MS_GEN_SAFE_CELL_EN
  localparam int MAX_MINES = 55;
`else
  localparam int MAX_MINES = 63;
`endif

  typedef struct packed {
    gen_state_t state;
    logic [6:0] placed;
    cell_idx_t  sweep_idx;
  } gen_dbg_t;

  // Bit k is set when cell k touches idx (including diagonals) and lies on
  // the board. The cell itself is never included. There is no wrap-around
  // between opposite edges.
  function automatic logic [CELLS-1:0] nbr_mask(input cell_idx_t idx);
    logic [CELLS-1:0] m;
    cell_idx_t        ni;
    int               row;
    int               col;
    int               r;
    int               c;
    m   = '0;
    row = int'(idx[5:3]);
    col = int'(idx[2:0]);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r  = row + dr;
        c  = col + dc;
        ni = cell_idx_t'(r * BOARD_W + c);
        if (!(dr == 0 && dc == 0) && r >= 0 && r < BOARD_W && c >= 0 && c < BOARD_W) begin
          m[ni] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [ADJ_W-1:0] count_adj(input cell_idx_t idx,
                                                 input logic [CELLS-1:0] mine);
    return ADJ_W'($countones(nbr_mask(idx) & mine));
  endfunction

endpackage

// File: rtl/ms_mine_gen_if.sv
// ms_mine_gen_if: bundle between the minefield generator and its consumer.
//   gen_reset  consumer -> generator  start/restart request
//   safe_cell  consumer -> generator  cell kept mine-free (MS_GEN_SAFE_CELL_EN)
//   mine       generator -> consumer  64-bit mine map
//   adj        generator -> consumer  4-bit adjacent-mine count per cell
//   gen_done   generator -> consumer  board and adj valid
//   busy       generator -> consumer  generation in progress
//   dbg        generator -> consumer  FSM state, placed count, sweep index
//
// Handshake: gen_reset is a one-way request with no ready. It is sampled
// every clock and always wins, even while busy or done. gen_done is a level
// "valid". It is held until the next request or reset, and while it is high
// mine/adj are frozen.
interface ms_mine_gen_if;
  import ms_pkg::*;

  logic                   gen_reset;
  cell_idx_t              safe_cell;
  logic [CELLS-1:0]       mine;
  logic [CELLS*ADJ_W-1:0] adj;
  logic                   gen_done;
  logic                   busy;
  gen_dbg_t               dbg;

  modport master (
    input  gen_reset, safe_cell,
    output mine, adj, gen_done, busy, dbg
  );

  modport slave (
    output gen_reset, safe_cell,
    input  mine, adj, gen_done, busy, dbg
  );

endinterface

// File: rtl/ms_lfsr16.sv
// ms_lfsr16: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11.
//   clk    in   system clock
//   reset  in   synchronous active-high, loads seed
//   seed   in   16-bit load value (nonzero)
//   q      out  current LFSR state; advances every clock out of reset
module ms_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Right-shifting Galois form. The feedback bit is the LSB, applied to
  // taps 16, 14, 13 and 11.
  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/ms_mine_gen.sv
// ms_mine_gen: minefield generator for the 8x8 board.
//   The generator clears the board and drops MINE_COUNT mines on distinct
//   pseudo-random cells. It then sweeps all 64 cells, one per clock, and
//   stores each cell's adjacent-mine count.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-high; has priority over gen_reset
//     gen_bus  ms_mine_gen_if.master: gen_reset, safe_cell in;
//              mine, adj, gen_done, busy, dbg out
//   Parameters: MINE_COUNT (1..63, or 1..55 with the safe cell enabled),
//               SEED (nonzero LFSR load value).
//   Optional feature macro: MS_GEN_SAFE_CELL_EN. When it is defined,
//   safe_cell is captured in CLEAR, and that cell and its neighbours never
//   receive a mine.
module ms_mine_gen
  import ms_pkg::*;
#(
  parameter int          MINE_COUNT = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic             clk,
  input logic             reset,
  ms_mine_gen_if.master   gen_bus
);

  if (MINE_COUNT < 1 || MINE_COUNT > MAX_MINES) begin : g_bad_mine_count
    $error("ms_mine_gen: MINE_COUNT=%0d outside legal range 1..%0d", MINE_COUNT, MAX_MINES);
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("ms_mine_gen: SEED must be nonzero");
  end

  gen_state_t             state;
  logic [CELLS-1:0]       mine_q;
  logic [CELLS*ADJ_W-1:0] adj_q;
  logic                   gen_done_q;
  logic [6:0]             placed;
  cell_idx_t              sweep_idx;
  logic [15:0]            lfsr;

  cell_idx_t              cand;
  logic                   cand_excl;
  logic                   pick_ok;
  logic                   last_pick;
  logic                   unused_lfsr_hi;

  // The LFSR runs in every state. The moment the user asks for a board
  // therefore decides which candidate sequence the board is built from.
  ms_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr)
  );

  assign cand           = lfsr[5:0];
  assign unused_lfsr_hi = ^lfsr[15:6];

`ifdef MS_GEN_SAFE_CELL_EN
  // Exclusion mask captured in CLEAR. It holds the safe cell plus its
  // in-board neighbours.
  logic [CELLS-1:0] excl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      excl_q <= '0;
    end else if (!gen_bus.gen_reset && state == GS_CLEAR) begin
      excl_q <= nbr_mask(gen_bus.safe_cell) | (64'd1 << gen_bus.safe_cell);
    end
  end

  assign cand_excl = excl_q[cand];
`else
  logic unused_safe_cell;
  assign unused_safe_cell = ^gen_bus.safe_cell;
  assign cand_excl        = 1'b0;
`endif

  assign pick_ok   = !mine_q[cand] && !cand_excl;
  // When this attempt lands, placed will reach MINE_COUNT.
  assign last_pick = pick_ok && (placed == 7'(MINE_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GS_IDLE;
      mine_q     <= '0;
      adj_q      <= '0;
      gen_done_q <= 1'b0;
      placed     <= '0;
      sweep_idx  <= '0;
    end else if (gen_bus.gen_reset) begin
      // A restart wins over any in-flight work. The clearing happens in
      // CLEAR on the next clock.
      state <= GS_CLEAR;
    end else begin
      case (state)
        GS_IDLE: begin
          state <= GS_IDLE;
        end
        GS_CLEAR: begin
          mine_q     <= '0;
          adj_q      <= '0;
          placed     <= '0;
          gen_done_q <= 1'b0;
          sweep_idx  <= '0;
          state      <= GS_PICK;
        end
        GS_PICK: begin
          // A rejected candidate costs one cycle and changes nothing. The
          // free-running LFSR offers a new candidate on the next clock.
          if (pick_ok) begin
            mine_q[cand] <= 1'b1;
            placed       <= placed + 7'd1;
          end
          if (last_pick) begin
            sweep_idx <= '0;
            state     <= GS_COUNT;
          end
        end
        GS_COUNT: begin
          adj_q[{sweep_idx, 2'b00} +: ADJ_W] <= count_adj(sweep_idx, mine_q);
          if (sweep_idx == cell_idx_t'(CELLS - 1)) begin
            state <= GS_DONE;
          end else begin
            sweep_idx <= sweep_idx + 6'd1;
          end
        end
        GS_DONE: begin
          gen_done_q <= 1'b1;
        end
        default: begin
          state <= GS_IDLE;
        end
      endcase
    end
  end

  assign gen_bus.mine     = mine_q;
  assign gen_bus.adj      = adj_q;
  assign gen_bus.gen_done = gen_done_q;
  assign gen_bus.busy     = (state == GS_CLEAR) || (state == GS_PICK) || (state == GS_COUNT);
  assign gen_bus.dbg      = '{state: state, placed: placed, sweep_idx: sweep_idx};

endmodule
